// File: rtl/icache_fill_responder.sv
// Memory-side responder for the icache line fill: reads four SRAM words and returns them as beats.
// Define ICACHE_FILL_CWF_EN for critical-word-first ordering (default build: words 0,1,2,3).
module icache_fill_responder #(
   parameter int unsigned ACCESS_LAT = 2,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mem_req,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              mem_ready,
   output logic [31:0]       mem_data,
   output logic [1:0]        beat_num,
   output logic              bus_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd_en,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [1:0]        issue_cnt;
   logic [1:0]        start_word;
   logic [1:0]        rd_word;
   logic [ADDR_W-5:0] base;
   logic [1:0]        word;
   logic              abort;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^req_addr[3:0];

   // 2-bit add keeps the word index inside the 16-byte line
   always_comb begin
      word  = start_word + issue_cnt;
      abort = !mem_req && (state == WAIT || state == READ || state == DRAIN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         issue_cnt  <= '0;
         start_word <= '0;
         rd_word    <= '0;
         base       <= '0;
         mem_ready  <= 1'b0;
         mem_data   <= '0;
         beat_num   <= '0;
         bus_busy   <= 1'b0;
         ram_addr   <= '0;
         ram_rd_en  <= 1'b0;
      end else begin
         // SRAM data for the read issued last cycle becomes this cycle's beat
         mem_ready <= ram_rd_en;
         if (ram_rd_en) begin
            mem_data <= ram_rdata;
            beat_num <= rd_word;
         end
         ram_rd_en <= 1'b0;

         if (abort) begin
            state     <= IDLE;
            bus_busy  <= 1'b0;
            mem_ready <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (mem_req) begin
                     base      <= req_addr[ADDR_W-1:4];
`ifdef ICACHE_FILL_CWF_EN
                     start_word <= req_addr[3:2];
`else
                     start_word <= '0;
`endif
                     wait_cnt  <= 4'(ACCESS_LAT);
                     issue_cnt <= '0;
                     bus_busy  <= 1'b1;
                     state     <= (ACCESS_LAT == 0) ? READ : WAIT;
                  end
               end
               WAIT: begin
                  wait_cnt <= wait_cnt - 4'd1;
                  if (wait_cnt == 4'd1)
                     state <= READ;
               end
               READ: begin
                  ram_rd_en <= 1'b1;
                  ram_addr  <= {base, word, 2'b00};
                  rd_word   <= word;
                  issue_cnt <= issue_cnt + 2'd1;
                  if (issue_cnt == 2'd3)
                     state <= DRAIN;
               end
               DRAIN: state <= DONE;
               DONE: begin
                  if (!mem_req) begin
                     state    <= IDLE;
                     bus_busy <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_icache_fill_responder.sv
// Directed bench for icache_fill_responder: cycle table for ACCESS_LAT=2 plus hand sequences.
// Expected word order follows ICACHE_FILL_CWF_EN when the bench is built with that macro.
module tb_icache_fill_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        rdy, busy, rd;
   logic [31:0] data, raddr, rdata;
   logic [1:0]  beat;

   logic        req0 = 1'b0;
   logic [31:0] addr0 = '0;
   logic        rdy0, busy0, rd0;
   logic [31:0] data0, raddr0, rdata0;
   logic [1:0]  beat0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // SRAM model: word at address a holds a; data is valid for capture at the next edge
   assign rdata  = rd  ? raddr  : 32'hDEAD_BEEF;
   assign rdata0 = rd0 ? raddr0 : 32'hDEAD_BEEF;

   icache_fill_responder #(.ACCESS_LAT(2), .ADDR_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .mem_req(req), .req_addr(addr),
      .mem_ready(rdy), .mem_data(data), .beat_num(beat), .bus_busy(busy),
      .ram_addr(raddr), .ram_rd_en(rd), .ram_rdata(rdata));

   icache_fill_responder #(.ACCESS_LAT(0), .ADDR_W(32)) dut0 (
      .clk(clk), .reset_n(reset_n), .mem_req(req0), .req_addr(addr0),
      .mem_ready(rdy0), .mem_data(data0), .beat_num(beat0), .bus_busy(busy0),
      .ram_addr(raddr0), .ram_rd_en(rd0), .ram_rdata(rdata0));

   typedef struct {
      logic req;
      logic busy;
      logic rd;
      int   rd_i;
      logic rdy;
      int   rdy_i;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] word_of(input logic [31:0] a, input int i);
      logic [1:0] s;
`ifdef ICACHE_FILL_CWF_EN
      s = a[3:2];
`else
      s = 2'd0;
`endif
      return s + 2'(i);
   endfunction

   function automatic logic [31:0] exp_addr(input logic [31:0] a, input int i);
      return {a[31:4], word_of(a, i), 2'b00};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Row n: mem_req seen at edge n, outputs expected in the cycle after edge n
   task automatic run_table(input logic [31:0] a, input string tag);
      for (int n = 0; n < 11; n++) begin
         req  = tbl[n].req;
         addr = a;
         tick();
         chk({tag, "_busy"}, 32'(busy), 32'(tbl[n].busy));
         chk({tag, "_rd_en"}, 32'(rd), 32'(tbl[n].rd));
         if (tbl[n].rd)
            chk({tag, "_ram_addr"}, raddr, exp_addr(a, tbl[n].rd_i));
         chk({tag, "_ready"}, 32'(rdy), 32'(tbl[n].rdy));
         if (tbl[n].rdy) begin
            chk({tag, "_beat"}, 32'(beat), 32'(word_of(a, tbl[n].rdy_i)));
            chk({tag, "_data"}, data, exp_addr(a, tbl[n].rdy_i));
         end
      end
   endtask

   task automatic watch(input int n, output int n_rdy, output int n_rd);
      n_rdy = 0;
      n_rd  = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (rdy) n_rdy++;
         if (rd)  n_rd++;
      end
   endtask

   initial begin
      int n_rdy, n_rd;
      logic exp_b, exp_r;

      tbl[0]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 0};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 2, 1'b1, 1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 3, 1'b1, 2};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 3};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 0};

      // reset state (two edges pass with reset held)
      #20;
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_beat", 32'(beat), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ram_addr", raddr, 32'd0);
      chk("rst_rd_en", 32'(rd), 32'd0);
      #2 reset_n = 1'b1;
      tick();

      run_table(32'h0000_1004, "fill1004");
      run_table(32'h0000_2008, "fill2008");
      run_table(32'hFFFF_FFFC, "wrapline");

      // back-to-back on the zero-latency instance
      addr0 = 32'h0000_8000;
      for (int c = 0; c < 15; c++) begin
         req0 = (c <= 6) || (c >= 8 && c <= 13);
         tick();
         exp_b = (c <= 6) || (c >= 8 && c <= 13);
         exp_r = (c >= 2 && c <= 5) || (c >= 10 && c <= 13);
         chk("b2b_busy", 32'(busy0), 32'(exp_b));
         chk("b2b_ready", 32'(rdy0), 32'(exp_r));
         if (exp_r) begin
            chk("b2b_beat", 32'(beat0), 32'(word_of(addr0, (c >= 10) ? c - 10 : c - 2)));
            chk("b2b_data", data0, exp_addr(addr0, (c >= 10) ? c - 10 : c - 2));
         end
      end
      req0 = 1'b0;

      // abort: requester drops mem_req as soon as it sees the second beat
      req  = 1'b1;
      addr = 32'h0000_7000;
      for (int k = 0; k < 6; k++) tick();
      chk("abort_pre_ready", 32'(rdy), 32'd1);
      chk("abort_pre_beat", 32'(beat), 32'(word_of(addr, 1)));
      req = 1'b0;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rd_en", 32'(rd), 32'd0);
      chk("abort_ready", 32'(rdy), 32'd0);
      watch(4, n_rdy, n_rd);
      chk("abort_late_beats", 32'(n_rdy), 32'd0);
      run_table(32'h0000_7004, "after_abort");

      // asynchronous reset during the second beat
      req  = 1'b1;
      addr = 32'h0000_5000;
      for (int k = 0; k < 6; k++) tick();
      chk("rstmid_pre_ready", 32'(rdy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_ready", 32'(rdy), 32'd0);
      chk("rstmid_data", data, 32'd0);
      chk("rstmid_beat", 32'(beat), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_ram_addr", raddr, 32'd0);
      chk("rstmid_rd_en", 32'(rd), 32'd0);
      req = 1'b0;
      #2 reset_n = 1'b1;
      watch(6, n_rdy, n_rd);
      chk("rstmid_late_beats", 32'(n_rdy), 32'd0);
      chk("rstmid_late_reads", 32'(n_rd), 32'd0);
      chk("rstmid_idle_busy", 32'(busy), 32'd0);
      run_table(32'h0000_400C, "after_reset");

      // mem_req held high well past the fourth beat
      req  = 1'b1;
      addr = 32'h0000_6000;
      watch(30, n_rdy, n_rd);
      chk("hold_beats", 32'(n_rdy), 32'd4);
      chk("hold_reads", 32'(n_rd), 32'd4);
      chk("hold_busy", 32'(busy), 32'd1);
      req = 1'b0;
      tick();
      chk("hold_release_busy", 32'(busy), 32'd0);
      watch(3, n_rdy, n_rd);
      chk("hold_idle_beats", 32'(n_rdy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
